// File: rtl/lfsr_seq_checker_if.sv
// Stream and status bundle between an LFSR source/bench and the sequence checker.
`timescale 1ns/1ps

interface lfsr_seq_checker_if #(
    parameter int N     = 4,
    parameter int ERR_W = 8
);
    logic             start;
    logic [N-1:0]     seed;
    logic             din_valid;
    logic [N-1:0]     din;
    logic             busy;
    logic             mismatch;
    logic [ERR_W-1:0] err_count;
    logic [N:0]       period;
    logic             done;
    logic             timeout;

    modport master (
        output start, seed, din_valid, din,
        input  busy, mismatch, err_count, period, done, timeout
    );

    modport slave (
        input  start, seed, din_valid, din,
        output busy, mismatch, err_count, period, done, timeout
    );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Checks an LFSR state stream step by step against its feedback polynomial
// and measures the seed-to-seed period.
`timescale 1ns/1ps

// state     | meaning
// IDLE      | armed by nothing; waits for start
// WAIT_SEED | seed latched; waits for din == seed
// RUN       | checking each valid sample against the expected next state
// DONE      | period/err_count/timeout frozen; start re-arms
module lfsr_seq_checker #(
    parameter int N     = 4,
    parameter int ERR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    lfsr_seq_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SEED = 2'd1,
        RUN       = 2'd2,
        DONE      = 2'd3
    } state_t;

    // One tap mask per supported width; must match the LFSR stage.
    localparam logic [7:0] TAPS =
        (N == 2) ? 8'h03 :
        (N == 3) ? 8'h06 :
        (N == 4) ? 8'h0C :
        (N == 5) ? 8'h14 :
        (N == 6) ? 8'h30 :
        (N == 7) ? 8'h60 :
                   8'hB8;

    localparam logic [N-1:0] TAP_MASK = TAPS[N-1:0];
    localparam logic [N:0]   CNT_MAX  = {1'b1, {N{1'b0}}};
    localparam logic [N:0]   CNT_ONE  = {{N{1'b0}}, 1'b1};

    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] x);
        logic fb;
        fb = ^(x & TAP_MASK);
        return {x[N-2:0], fb};
    endfunction

    state_t           state_q, state_nxt;
    logic [N-1:0]     seed_q, seed_nxt;
    logic [N-1:0]     exp_q, exp_nxt;
    logic [N:0]       cnt_q, cnt_nxt;
    logic [ERR_W-1:0] err_q, err_nxt;
    logic [N:0]       per_q, per_nxt;
    logic             to_q, to_nxt;
    logic             mis_q, mis_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            seed_q  <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            per_q   <= '0;
            to_q    <= 1'b0;
            mis_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            seed_q  <= seed_nxt;
            exp_q   <= exp_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
            per_q   <= per_nxt;
            to_q    <= to_nxt;
            mis_q   <= mis_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        seed_nxt  = seed_q;
        exp_nxt   = exp_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        per_nxt   = per_q;
        to_nxt    = to_q;
        mis_nxt   = 1'b0;

        if (bus.start) begin
            seed_nxt  = bus.seed;
            err_nxt   = '0;
            per_nxt   = '0;
            to_nxt    = 1'b0;
            state_nxt = WAIT_SEED;
            // A sample arriving with start is judged against the new seed.
            if (bus.din_valid && (bus.din == bus.seed)) begin
                exp_nxt   = lfsr_next(bus.seed);
                cnt_nxt   = CNT_ONE;
                state_nxt = RUN;
            end
        end else if (bus.din_valid) begin
            case (state_q)
                WAIT_SEED: begin
                    if (bus.din == seed_q) begin
                        exp_nxt   = lfsr_next(seed_q);
                        cnt_nxt   = CNT_ONE;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (bus.din != exp_q) begin
                        mis_nxt = 1'b1;
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_nxt = err_q + 1'b1;
                        end
                    end
                    // Re-seed from the observed value so one bad sample costs two errors.
                    exp_nxt = lfsr_next(bus.din);
                    if ((bus.din == seed_q) && (bus.din == exp_q)) begin
                        per_nxt   = cnt_q;
                        state_nxt = DONE;
                    end else if (cnt_q == CNT_MAX) begin
                        to_nxt    = 1'b1;
                        per_nxt   = cnt_q;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_nxt = (state_nxt == WAIT_SEED) || (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
    end

    assign bus.busy      = busy_q;
    assign bus.mismatch  = mis_q;
    assign bus.err_count = err_q;
    assign bus.period    = per_q;
    assign bus.done      = done_q;
    assign bus.timeout   = to_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker (N=4): vector table plus stream scenarios,
// expectations queued at drive time and compared when the outputs settle.
`timescale 1ns/1ps

module tb_lfsr_seq_checker;

    logic clk;
    logic reset;

    lfsr_seq_checker_if #(.N(4), .ERR_W(8)) bus ();

    lfsr_seq_checker #(.N(4), .ERR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       busy;
        logic       mis;
        logic [7:0] err;
        logic [4:0] per;
        logic       done;
        logic       to;
    } exp_t;

    typedef struct {
        logic       r;
        logic       s;
        logic [3:0] sd;
        logic       v;
        logic [3:0] d;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input string n, input logic b, input logic mi,
                                input logic [7:0] er, input logic [4:0] pe,
                                input logic dn, input logic tm);
        exp_t e;
        e.name = n; e.busy = b; e.mis = mi; e.err = er;
        e.per = pe; e.done = dn; e.to = tm;
        return e;
    endfunction

    function automatic vec_t mkv(input logic r, input logic s, input logic [3:0] sd,
                                 input logic v, input logic [3:0] d, input exp_t e);
        vec_t x;
        x.r = r; x.s = s; x.sd = sd; x.v = v; x.d = d; x.e = e;
        return x;
    endfunction

    task automatic apply(input logic r, input logic s, input logic [3:0] sd,
                         input logic v, input logic [3:0] d, input exp_t e);
        reset         = r;
        bus.start     = s;
        bus.seed      = sd;
        bus.din_valid = v;
        bus.din       = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checks++;
            if ({bus.busy, bus.mismatch, bus.err_count, bus.period, bus.done, bus.timeout} !==
                {cur.busy, cur.mis, cur.err, cur.per, cur.done, cur.to}) begin
                errors++;
                $display("FAIL %s: got busy=%0b mis=%0b err=%0d per=%0d done=%0b to=%0b, expected busy=%0b mis=%0b err=%0d per=%0d done=%0b to=%0b",
                         cur.name, bus.busy, bus.mismatch, bus.err_count, bus.period, bus.done, bus.timeout,
                         cur.busy, cur.mis, cur.err, cur.per, cur.done, cur.to);
            end
        end
    end

    vec_t       tbl[18];
    logic [3:0] seq[15];
    logic [3:0] d;
    logic [7:0] err;
    logic       mis;

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.seed = '0; bus.din_valid = 1'b0; bus.din = '0;

        // Maximal-length x^4 + x^3 + 1 orbit starting at 1.
        seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

        tbl[0]  = mkv(1, 0, 4'h0, 0, 4'h0, mk("reset",            0, 0, 8'd0, 5'd0, 0, 0));
        tbl[1]  = mkv(0, 0, 4'h0, 1, 4'h0, mk("idle_ignore",      0, 0, 8'd0, 5'd0, 0, 0));
        tbl[2]  = mkv(0, 1, 4'h0, 0, 4'h0, mk("arm_seed0",        1, 0, 8'd0, 5'd0, 0, 0));
        tbl[3]  = mkv(0, 0, 4'h0, 1, 4'h5, mk("wait_ignore",      1, 0, 8'd0, 5'd0, 0, 0));
        tbl[4]  = mkv(0, 0, 4'h0, 1, 4'h0, mk("seed0_hit",        1, 0, 8'd0, 5'd0, 0, 0));
        tbl[5]  = mkv(0, 0, 4'h0, 0, 4'h0, mk("hold_gap",         1, 0, 8'd0, 5'd0, 0, 0));
        tbl[6]  = mkv(0, 0, 4'h0, 1, 4'h0, mk("seed0_done",       0, 0, 8'd0, 5'd1, 1, 0));
        tbl[7]  = mkv(0, 0, 4'h0, 1, 4'h3, mk("done_hold",        0, 0, 8'd0, 5'd1, 1, 0));
        tbl[8]  = mkv(0, 1, 4'h8, 0, 4'h0, mk("restart_8",        1, 0, 8'd0, 5'd0, 0, 0));
        tbl[9]  = mkv(0, 0, 4'h0, 1, 4'h8, mk("seed8_hit",        1, 0, 8'd0, 5'd0, 0, 0));
        tbl[10] = mkv(0, 0, 4'h0, 1, 4'h1, mk("run_ok",           1, 0, 8'd0, 5'd0, 0, 0));
        tbl[11] = mkv(0, 0, 4'h0, 1, 4'h7, mk("run_bad",          1, 1, 8'd1, 5'd0, 0, 0));
        tbl[12] = mkv(0, 0, 4'h0, 0, 4'h0, mk("mis_clear",        1, 0, 8'd1, 5'd0, 0, 0));
        tbl[13] = mkv(1, 1, 4'h8, 1, 4'h8, mk("reset_wins",       0, 0, 8'd0, 5'd0, 0, 0));
        tbl[14] = mkv(0, 0, 4'h0, 1, 4'h8, mk("post_reset_ign",   0, 0, 8'd0, 5'd0, 0, 0));
        tbl[15] = mkv(0, 1, 4'h2, 1, 4'h2, mk("start_same_cycle", 1, 0, 8'd0, 5'd0, 0, 0));
        tbl[16] = mkv(0, 0, 4'h0, 1, 4'h5, mk("run_after_same",   1, 1, 8'd1, 5'd0, 0, 0));
        tbl[17] = mkv(1, 0, 4'h0, 0, 4'h0, mk("reset_end",        0, 0, 8'd0, 5'd0, 0, 0));

        for (int k = 0; k < 18; k++) begin
            apply(tbl[k].r, tbl[k].s, tbl[k].sd, tbl[k].v, tbl[k].d, tbl[k].e);
        end

        // Mode 0: clean stream, 1: valid gaps between samples, 2: sample 5 corrupted.
        for (int m = 0; m < 3; m++) begin
            apply(0, 1, 4'h1, 0, 4'h0, mk("stream_arm", 1, 0, 8'd0, 5'd0, 0, 0));
            apply(0, 0, 4'h0, 1, 4'h1, mk("stream_seed", 1, 0, 8'd0, 5'd0, 0, 0));
            err = 8'd0;
            for (int i = 1; i <= 15; i++) begin
                d   = seq[i % 15];
                mis = (m == 2) && (i == 5 || i == 6);
                if (m == 2 && i == 5) d = d ^ 4'h1;
                if (mis) err = err + 8'd1;
                apply(0, 0, 4'h0, 1, d,
                      mk((i == 15) ? "stream_done" : "stream_run", i < 15, mis, err,
                         (i == 15) ? 5'd15 : 5'd0, i == 15, 0));
                if (m == 1 && i < 15) begin
                    apply(0, 0, 4'h0, 0, 4'hF, mk("stream_gap", 1, 0, err, 5'd0, 0, 0));
                end
            end
        end

        // Constant garbage after the seed: every sample is an error, then timeout.
        apply(0, 1, 4'h1, 0, 4'h0, mk("to_arm",  1, 0, 8'd0, 5'd0, 0, 0));
        apply(0, 0, 4'h0, 1, 4'h1, mk("to_seed", 1, 0, 8'd0, 5'd0, 0, 0));
        for (int i = 1; i <= 16; i++) begin
            apply(0, 0, 4'h0, 1, 4'hA,
                  mk((i == 16) ? "to_done" : "to_run", i < 16, 1, 8'(i),
                     (i == 16) ? 5'd16 : 5'd0, i == 16, i == 16));
        end
        apply(0, 0, 4'h0, 1, 4'hA, mk("to_hold",  0, 0, 8'd16, 5'd16, 1, 1));
        apply(0, 1, 4'h3, 0, 4'h0, mk("to_clear", 1, 0, 8'd0, 5'd0, 0, 0));
        apply(1, 0, 4'h0, 0, 4'h0, mk("final_reset", 0, 0, 8'd0, 5'd0, 0, 0));

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
